// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode-side controls and fetch-side outputs of the PC sequencer.
interface pc_sequencer_if #(parameter int D = 12);
    logic         start;
    logic [D-1:0] start_addr;
    logic         stall;
    logic         halt;
    logic         branch_en;
    logic         abs_jump;
    logic         call;
    logic         ret;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         fetch_valid;
    logic         done;
    logic         stack_err;
    modport master (
        output start, start_addr, stall, halt, branch_en, abs_jump, call, ret, target,
        input  prog_ctr, fetch_valid, done, stack_err
    );
    modport slave (
        input  start, start_addr, stall, halt, branch_en, abs_jump, call, ret, target,
        output prog_ctr, fetch_valid, done, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with relative/absolute branches, call/return stack
// and an IDLE/RUN/HALTED run-control FSM.
module pc_sequencer #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    pc_sequencer_if.slave  bus
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(STACK_DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
    state_t         r_state, w_state_nxt;
    logic [D-1:0]   r_pc, w_pc_nxt;
    logic [AW:0]    r_sp, w_sp_nxt, w_sp_m1;
    logic [D-1:0]   r_stack [STACK_DEPTH];
    logic           r_err, w_err_nxt, w_push;
    logic [D-1:0]   w_pc_inc, w_br;
    assign w_pc_inc = r_pc + 1'b1;
    assign w_br     = bus.abs_jump ? bus.target : r_pc + bus.target;
    assign w_sp_m1  = r_sp - 1'b1;
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        if (r_state != S_RUN) begin
            if (bus.start) begin
                w_state_nxt = S_RUN;
                w_pc_nxt    = bus.start_addr;
                w_sp_nxt    = '0;
                w_err_nxt   = 1'b0;
            end
        end else if (!bus.stall) begin
            if (bus.halt) begin
                w_state_nxt = S_HALTED;
            end else if (bus.ret) begin
                if (r_sp == '0) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALTED;
                end else begin
                    w_pc_nxt = r_stack[w_sp_m1[AW-1:0]];
                    w_sp_nxt = w_sp_m1;
                end
            end else if (bus.branch_en && bus.call && r_sp == SP_FULL) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_HALTED;
            end else if (bus.branch_en) begin
                w_pc_nxt = w_br;
                w_push   = bus.call;
                w_sp_nxt = bus.call ? r_sp + 1'b1 : r_sp;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sp    <= w_sp_nxt;
            r_err   <= w_err_nxt;
            if (w_push) r_stack[r_sp[AW-1:0]] <= w_pc_inc;
        end
    end
    assign bus.prog_ctr    = r_pc;
    assign bus.fetch_valid = (r_state == S_RUN);
    assign bus.done        = (r_state == S_HALTED);
    assign bus.stack_err   = r_err;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed PC/flag expectations.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    always #5 clk = ~clk;
    pc_sequencer_if #(.D(12)) bus ();
    pc_sequencer #(.D(12), .STACK_DEPTH(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic st(input string tag, input logic [11:0] pc, input logic fv, input logic dn, input logic er);
        chk({tag, ".pc"}, 32'(bus.prog_ctr), 32'(pc));
        chk({tag, ".fv"}, 32'(bus.fetch_valid), 32'(fv));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
        chk({tag, ".err"}, 32'(bus.stack_err), 32'(er));
    endtask
    task automatic clr();
        bus.start = 0; bus.start_addr = '0; bus.stall = 0; bus.halt = 0;
        bus.branch_en = 0; bus.abs_jump = 0; bus.call = 0; bus.ret = 0; bus.target = '0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask
    task automatic go(input logic [11:0] a);
        bus.start = 1; bus.start_addr = a; tick();
    endtask
    task automatic br(input logic aj, input logic c, input logic [11:0] t);
        bus.branch_en = 1; bus.abs_jump = aj; bus.call = c; bus.target = t; tick();
    endtask
    initial begin
        clr();
        tick(); tick();
        st("reset", 12'h000, 0, 0, 0);
        rst = 0;
        tick();
        st("idle_hold", 12'h000, 0, 0, 0);
        go(12'h010);
        st("start", 12'h010, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("inc", 32'(bus.prog_ctr), 32'h010 + i);
        end
        go(12'h700);
        st("start_in_run", 12'h016, 1, 0, 0);
        br(1, 0, 12'h020);  chk("abs20", 32'(bus.prog_ctr), 32'h020);
        br(0, 0, 12'hFFB);  chk("rel_m5", 32'(bus.prog_ctr), 32'h01B);
        br(0, 0, 12'h014);  chk("rel_p20", 32'(bus.prog_ctr), 32'h02F);
        br(1, 0, 12'h100);  chk("abs100", 32'(bus.prog_ctr), 32'h100);
        br(1, 0, 12'hFFF);  chk("absFFF", 32'(bus.prog_ctr), 32'hFFF);
        tick();             chk("wrap_inc", 32'(bus.prog_ctr), 32'h000);
        br(1, 0, 12'h002);  chk("abs002", 32'(bus.prog_ctr), 32'h002);
        br(0, 0, 12'hFFC);  chk("wrap_rel", 32'(bus.prog_ctr), 32'hFFE);
        br(1, 0, 12'h040);
        br(1, 1, 12'h200);  st("call200", 12'h200, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            bus.stall = 1; bus.ret = 1; bus.halt = 1; tick();
            st("stall", 12'h200, 1, 0, 0);
        end
        bus.ret = 1; tick();
        chk("ret041", 32'(bus.prog_ctr), 32'h041);
        br(1, 1, 12'h300);  chk("call1", 32'(bus.prog_ctr), 32'h300);
        br(1, 1, 12'h310);  chk("call2", 32'(bus.prog_ctr), 32'h310);
        br(1, 1, 12'h320);  chk("call3", 32'(bus.prog_ctr), 32'h320);
        br(1, 1, 12'h330);  st("call4", 12'h330, 1, 0, 0);
        bus.ret = 1; tick();
        chk("pop_top", 32'(bus.prog_ctr), 32'h321);
        br(1, 1, 12'h330);  st("refill", 12'h330, 1, 0, 0);
        br(1, 1, 12'h340);  st("overflow", 12'h330, 0, 1, 1);
        br(1, 0, 12'h555);  st("halted_hold", 12'h330, 0, 1, 1);
        go(12'h050);        st("restart", 12'h050, 1, 0, 0);
        bus.ret = 1; tick();
        st("underflow", 12'h050, 0, 1, 1);
        go(12'h000);        st("restart0", 12'h000, 1, 0, 0);
        bus.call = 1; tick();
        chk("call_no_be", 32'(bus.prog_ctr), 32'h001);
        br(1, 1, 12'h010);  chk("call010", 32'(bus.prog_ctr), 32'h010);
        bus.ret = 1; bus.branch_en = 1; bus.abs_jump = 1; bus.target = 12'h500; tick();
        st("ret_wins", 12'h002, 1, 0, 0);
        bus.ret = 1; tick();
        st("ret_empty", 12'h002, 0, 1, 1);
        go(12'h030);
        tick(); tick(); tick();
        chk("pc033", 32'(bus.prog_ctr), 32'h033);
        bus.halt = 1; br(1, 0, 12'h100);
        st("halt", 12'h033, 0, 1, 0);
        go(12'h075);
        tick(); tick();
        st("pc077", 12'h077, 1, 0, 0);
        rst = 1; bus.branch_en = 1; bus.abs_jump = 1; bus.target = 12'h123; tick();
        st("mid_reset", 12'h000, 0, 0, 0);
        rst = 0; tick();
        st("post_reset_idle", 12'h000, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that consumes the branch target produced by the PC target controller and turns it into the instruction-fetch address stream. It holds the architectural program counter, advances it by one each instruction, applies relative branches, absolute jumps and call/return through a 4-entry return-address stack, and runs a start/run/halt state machine that signals program completion to the testbench/top level. It sits between the decode stage (branch/halt controls) and instruction ROM (address output).

## Interface
- D, 12, width of program counter and target
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2)

- Clk  input  1  single system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state
- Start  input  1  one-cycle pulse; loads StartAddr and begins execution (honoured in IDLE or HALTED only)
- StartAddr  input  D  first instruction address for this run
- Stall  input  1  hold PC and ignore all control inputs this cycle (RUN only)
- Halt  input  1  current instruction is halt
- BranchEn  input  1  take branch/jump this cycle
- AbsJump  input  1  with BranchEn: 1 = absolute, 0 = PC-relative
- Call  input  1  with BranchEn: push return address before branching
- Ret  input  1  pop return address into PC
- Target  input  D  branch target from PC target controller; signed offset (relative) or address (absolute)
- ProgCtr  output  D  registered fetch address
- FetchValid  output  1  ProgCtr is a live instruction address (state RUN)
- Done  output  1  program has halted
- StackErr  output  1  sticky: return stack overflow or underflow

## Operation
- States: IDLE, RUN, HALTED.
- Reset: state IDLE, ProgCtr 0, FetchValid 0, Done 0, StackErr 0, stack pointer 0 (empty), stack contents 0.
- IDLE: Start → ProgCtr ← StartAddr, RUN. All other inputs ignored.
- RUN, Stall=1: ProgCtr, stack, state unchanged; every other input ignored.
- RUN, Stall=0, priority highest first:
  - Halt: ProgCtr unchanged, → HALTED.
  - Ret: if stack empty → StackErr ← 1, ProgCtr unchanged, → HALTED; else ProgCtr ← top, pointer −1.
  - BranchEn & Call: if stack full → StackErr ← 1, ProgCtr unchanged, → HALTED; else push ProgCtr+1, then branch as below.
  - BranchEn: AbsJump ? ProgCtr ← Target : ProgCtr ← ProgCtr + Target (Target sign-extended, D-bit result, wraps mod 2^D).
  - else ProgCtr ← ProgCtr + 1 (wraps 2^D−1 → 0).
- Call without BranchEn is ignored; Ret with BranchEn: Ret wins.
- Pushed return address is ProgCtr+1 mod 2^D.
- HALTED: Done=1, ProgCtr held. Start → ProgCtr ← StartAddr, stack emptied, Done ← 0, StackErr ← 0, → RUN. Start in RUN ignored.
- Reset at any point, including mid-run or stall, overrides everything.

## Timing
- All inputs sampled on rising Clk; ProgCtr/FetchValid/Done/StackErr update one cycle after the controlling sample (registered outputs, no combinational input→output paths).
- Start sampled in cycle n → ProgCtr=StartAddr, FetchValid=1 in cycle n+1.
- Branch/call/ret: one-cycle latency, no bubble; next address visible the cycle after the sample.
- Halt sampled in cycle n → Done=1, FetchValid=0 in n+1; ProgCtr keeps halting instruction address.
- Stack error: StackErr and Done both rise in the same cycle.

## Test plan
- Reset then Start with StartAddr=0x010, 5 free cycles → ProgCtr 0x010,0x011,…,0x015; FetchValid=1; Done=0.
- At ProgCtr=0x020, BranchEn=1, AbsJump=0, Target=0xFFB (−5) → 0x01B; next Target=0x014 (+20) relative → 0x02F; AbsJump=1 Target=0x100 → 0x100.
- Wrap: ProgCtr=0xFFF increment → 0x000; ProgCtr=0x002, relative Target=0xFFC → 0xFFE.
- Call at 0x040 to absolute 0x200, Stall=1 for 2 cycles (PC stays 0x200), Ret → 0x041; 4 nested calls succeed, 5th → StackErr=1, Done=1, PC unchanged.
- Ret with empty stack → StackErr=1, Done=1; Start StartAddr=0x000 → StackErr=0, Done=0, ProgCtr=0x000.
- Halt and BranchEn together at 0x033 → Done=1, ProgCtr=0x033; Reset mid-run at ProgCtr=0x077 → next cycle ProgCtr=0, state IDLE, all flags 0.
